// File: rtl/apb2iob_reg_if.sv
// Bus bundle for the registered APB4-to-IOb bridge: APB slave side plus IOb master side.
// The slave modport is the bridge's view; master is the view of whatever drives APB and serves IOb.
interface apb2iob_reg_if #(
  parameter int APB_ADDR_W = 32,
  parameter int APB_DATA_W = 32,
  parameter int ADDR_W     = APB_ADDR_W,
  parameter int DATA_W     = APB_DATA_W
);
  logic                    apb_sel_i;
  logic                    apb_enable_i;
  logic                    apb_write_i;
  logic [APB_ADDR_W-1:0]   apb_addr_i;
  logic [APB_DATA_W-1:0]   apb_wdata_i;
  logic [APB_DATA_W/8-1:0] apb_wstrb_i;
  logic                    apb_ready_o;
  logic [APB_DATA_W-1:0]   apb_rdata_o;
  logic                    apb_slverr_o;

  logic                    iob_avalid_o;
  logic [ADDR_W-1:0]       iob_addr_o;
  logic [DATA_W-1:0]       iob_wdata_o;
  logic [DATA_W/8-1:0]     iob_wstrb_o;
  logic                    iob_rvalid_i;
  logic [DATA_W-1:0]       iob_rdata_i;
  logic                    iob_ready_i;

  modport slave (
    input  apb_sel_i, apb_enable_i, apb_write_i, apb_addr_i, apb_wdata_i, apb_wstrb_i,
    output apb_ready_o, apb_rdata_o, apb_slverr_o,
    output iob_avalid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o,
    input  iob_rvalid_i, iob_rdata_i, iob_ready_i
  );

  modport master (
    output apb_sel_i, apb_enable_i, apb_write_i, apb_addr_i, apb_wdata_i, apb_wstrb_i,
    input  apb_ready_o, apb_rdata_o, apb_slverr_o,
    input  iob_avalid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o,
    output iob_rvalid_i, iob_rdata_i, iob_ready_i
  );
endinterface

// File: rtl/apb2iob_reg.sv
// Registered APB4 slave to IOb master bridge (IDLE/REQ/RESP/DONE, one transfer outstanding).
// Define APB2IOB_TIMEOUT_EN to add a REQ/RESP timeout that completes the transfer with PSLVERR.
module apb2iob_reg #(
  parameter int APB_ADDR_W = 32,
  parameter int APB_DATA_W = 32,
  parameter int ADDR_W     = APB_ADDR_W,
  parameter int DATA_W     = APB_DATA_W,
  parameter int TIMEOUT_W  = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  apb2iob_reg_if.slave  bus
);
  localparam int STRB_W = DATA_W / 8;

  if (ADDR_W > APB_ADDR_W) begin : g_bad_addr_w
    $error("ADDR_W must not exceed APB_ADDR_W");
  end
  if (DATA_W != APB_DATA_W) begin : g_bad_data_w
    $error("DATA_W must equal APB_DATA_W");
  end
  if (TIMEOUT_W < 1) begin : g_bad_timeout_w
    $error("TIMEOUT_W must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic [STRB_W-1:0]   wstrb_reg, wstrb_next;
  logic                write_reg, write_next;
  logic [DATA_W-1:0]   rdata_reg, rdata_next;
  logic                slverr_reg, slverr_next;

  logic                addr_err;
  logic [STRB_W-1:0]   wstrb_in;
  logic                timed_out;

  // Reads carry an all-zero strobe on IOb, so mask each lane with the write flag.
  for (genvar gi = 0; gi < STRB_W; gi++) begin : g_strb
    assign wstrb_in[gi] = bus.apb_wstrb_i[gi] & bus.apb_write_i;
  end

  if (APB_ADDR_W > ADDR_W) begin : g_addr_chk
    assign addr_err = |bus.apb_addr_i[APB_ADDR_W-1:ADDR_W];
  end else begin : g_no_addr_chk
    assign addr_err = 1'b0;
  end

`ifdef APB2IOB_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TO_LAST = {TIMEOUT_W{1'b1}} - 1'b1;

  logic [TIMEOUT_W-1:0] to_cnt_reg, to_cnt_next;

  // Fires on the cycle whose edge would take the counter to its all-ones value.
  assign timed_out = (state_reg == ST_REQ || state_reg == ST_RESP) && (to_cnt_reg == TO_LAST);

  always_comb begin
    to_cnt_next = to_cnt_reg;
    if (state_reg == ST_IDLE) begin
      to_cnt_next = '0;
    end else if (state_reg == ST_REQ || state_reg == ST_RESP) begin
      to_cnt_next = to_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      to_cnt_reg <= '0;
    end else begin
      to_cnt_reg <= to_cnt_next;
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    wstrb_next  = wstrb_reg;
    write_next  = write_reg;
    rdata_next  = rdata_reg;
    slverr_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.apb_sel_i) begin
          addr_next  = bus.apb_addr_i[ADDR_W-1:0];
          wdata_next = bus.apb_wdata_i;
          write_next = bus.apb_write_i;
          wstrb_next = wstrb_in;
          if (addr_err) begin
            state_next  = ST_DONE;
            slverr_next = 1'b1;
            rdata_next  = '0;
          end else if (bus.apb_write_i && bus.apb_wstrb_i == '0) begin
            state_next = ST_DONE;
            rdata_next = '0;
          end else begin
            state_next = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (bus.iob_ready_i) begin
          if (write_reg) begin
            state_next = ST_DONE;
            rdata_next = '0;
          end else begin
            state_next = ST_RESP;
          end
        end else if (timed_out) begin
          state_next  = ST_DONE;
          slverr_next = 1'b1;
          rdata_next  = '0;
        end
      end
      ST_RESP: begin
        if (bus.iob_rvalid_i) begin
          state_next = ST_DONE;
          rdata_next = bus.iob_rdata_i;
        end else if (timed_out) begin
          state_next  = ST_DONE;
          slverr_next = 1'b1;
          rdata_next  = '0;
        end
      end
      default: begin
        // DONE lasts exactly one cycle; any PSEL seen here belongs to the finished transfer.
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg  <= ST_IDLE;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      wstrb_reg  <= '0;
      write_reg  <= 1'b0;
      rdata_reg  <= '0;
      slverr_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      wstrb_reg  <= wstrb_next;
      write_reg  <= write_next;
      rdata_reg  <= rdata_next;
      slverr_reg <= slverr_next;
    end
  end

  assign bus.apb_ready_o  = (state_reg == ST_DONE);
  assign bus.apb_slverr_o = slverr_reg;
  assign bus.apb_rdata_o  = rdata_reg;
  assign bus.iob_avalid_o = (state_reg == ST_REQ);
  assign bus.iob_addr_o   = addr_reg;
  assign bus.iob_wdata_o  = wdata_reg;
  assign bus.iob_wstrb_o  = wstrb_reg;

endmodule

// File: tb/tb_apb2iob_reg.sv
// Scoreboard bench for apb2iob_reg: directed APB transfers against a scripted IOb slave,
// with separate monitors popping expected IOb requests and APB responses.
module tb_apb2iob_reg;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int IAW = 16;
  localparam int TW  = 4;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          slverr;
  } resp_t;

  typedef struct {
    logic [IAW-1:0]  addr;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  resp_t resp_q[$];
  req_t  req_q[$];

  int            cfg_rdy_dly = 0;
  int            cfg_rv_dly = 1;
  logic [DW-1:0] cfg_rdata = '0;
  int            avalid_cnt = 0;
  int            req_cycles = 0;
  int            rv_cnt = 0;
  bit            rv_pend = 0;
  bit            stray_rv = 0;

  apb2iob_reg_if #(.APB_ADDR_W(AW), .APB_DATA_W(DW), .ADDR_W(IAW), .DATA_W(DW)) bus ();

  apb2iob_reg #(
    .APB_ADDR_W(AW), .APB_DATA_W(DW), .ADDR_W(IAW), .DATA_W(DW), .TIMEOUT_W(TW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // IOb slave: grants after cfg_rdy_dly REQ cycles, returns rvalid cfg_rv_dly cycles after accept.
  initial begin : iob_slave
    req_t r;
    bus.iob_ready_i  = 1'b0;
    bus.iob_rvalid_i = 1'b0;
    bus.iob_rdata_i  = 32'hBAD0_BAD0;
    forever begin
      @(negedge clk);
      bus.iob_rvalid_i = 1'b0;
      bus.iob_rdata_i  = 32'hBAD0_BAD0;
      if (rv_pend) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          bus.iob_rvalid_i = 1'b1;
          bus.iob_rdata_i  = cfg_rdata;
          rv_pend = 0;
        end
      end else if (stray_rv) begin
        bus.iob_rvalid_i = 1'b1;
        bus.iob_rdata_i  = 32'h0BAD_F00D;
        stray_rv = 0;
      end
      if (bus.iob_avalid_o === 1'b1) begin
        avalid_cnt++;
        if (req_cycles == cfg_rdy_dly) begin
          bus.iob_ready_i = 1'b1;
          if (req_q.size() == 0) begin
            check("iob_unexpected_request", 64'd1, 64'd0);
          end else begin
            r = req_q.pop_front();
            check("iob_addr", 64'(bus.iob_addr_o), 64'(r.addr));
            check("iob_wdata", 64'(bus.iob_wdata_o), 64'(r.wdata));
            check("iob_wstrb", 64'(bus.iob_wstrb_o), 64'(r.wstrb));
          end
          if (bus.iob_wstrb_o == '0) begin
            rv_pend = 1;
            rv_cnt  = cfg_rv_dly;
          end
        end else begin
          bus.iob_ready_i = 1'b0;
        end
        req_cycles++;
      end else begin
        bus.iob_ready_i = 1'b0;
        req_cycles = 0;
      end
    end
  end

  // APB response monitor: every PREADY cycle must match the oldest expected response.
  initial begin : apb_monitor
    resp_t e;
    forever begin
      @(negedge clk);
      if (bus.apb_ready_o === 1'b1) begin
        if (resp_q.size() == 0) begin
          check("apb_unexpected_ready", 64'd1, 64'd0);
        end else begin
          e = resp_q.pop_front();
          check("apb_rdata", 64'(bus.apb_rdata_o), 64'(e.rdata));
          check("apb_slverr", 64'(bus.apb_slverr_o), 64'(e.slverr));
        end
      end
    end
  end

  task automatic apb_xfer(input string tag, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [DW/8-1:0] strb,
                          input int rdy_dly, input int rv_dly, input logic [DW-1:0] rdat,
                          input bit exp_req, input logic [DW-1:0] exp_rdata, input logic exp_err,
                          input int exp_lat, input int exp_avalid);
    resp_t e;
    req_t  q;
    int    t0;
    int    lat;
    bit    seen;
    cfg_rdy_dly = rdy_dly;
    cfg_rv_dly  = rv_dly;
    cfg_rdata   = rdat;
    e.rdata  = exp_rdata;
    e.slverr = exp_err;
    resp_q.push_back(e);
    if (exp_req) begin
      q.addr  = addr[IAW-1:0];
      q.wdata = wdata;
      q.wstrb = wr ? strb : '0;
      req_q.push_back(q);
    end
    @(negedge clk);
    avalid_cnt = 0;
    bus.apb_sel_i    = 1'b1;
    bus.apb_enable_i = 1'b0;
    bus.apb_write_i  = wr;
    bus.apb_addr_i   = addr;
    bus.apb_wdata_i  = wdata;
    bus.apb_wstrb_i  = strb;
    t0 = cyc;
    @(negedge clk);
    bus.apb_enable_i = 1'b1;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (bus.apb_ready_o === 1'b1) seen = 1;
      else @(negedge clk);
    end
    lat = cyc - t0;
    check({tag, "_ready_seen"}, 64'(seen), 64'd1);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    @(negedge clk);
    bus.apb_sel_i    = 1'b0;
    bus.apb_enable_i = 1'b0;
    check({tag, "_ready_drop"}, 64'(bus.apb_ready_o), 64'd0);
    check({tag, "_slverr_drop"}, 64'(bus.apb_slverr_o), 64'd0);
    check({tag, "_rdata_hold"}, 64'(bus.apb_rdata_o), 64'(exp_rdata));
    check({tag, "_avalid_cycles"}, 64'(avalid_cnt), 64'(exp_avalid));
    $display("xfer %-10s %s addr=0x%08h lat=%0d avalid_cycles=%0d rdata=0x%08h slverr=%0b",
             tag, wr ? "WR" : "RD", addr, lat, avalid_cnt, bus.apb_rdata_o, exp_err);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bus.apb_sel_i    = 1'b0;
    bus.apb_enable_i = 1'b0;
    bus.apb_write_i  = 1'b0;
    bus.apb_addr_i   = '0;
    bus.apb_wdata_i  = '0;
    bus.apb_wstrb_i  = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_ready", 64'(bus.apb_ready_o), 64'd0);
    check("reset_slverr", 64'(bus.apb_slverr_o), 64'd0);
    check("reset_rdata", 64'(bus.apb_rdata_o), 64'd0);
    check("reset_avalid", 64'(bus.iob_avalid_o), 64'd0);
    check("reset_iob_addr", 64'(bus.iob_addr_o), 64'd0);
    check("reset_iob_wstrb", 64'(bus.iob_wstrb_o), 64'd0);
    rst = 1'b0;

    //       tag          wr    addr          wdata          strb  rdy rv  rdata          req exp_rdata      err lat av
    apb_xfer("wr_basic",  1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 1, 32'h0,          1, 32'h0,          0,  2, 1);
    apb_xfer("rd_wait",   1'b0, 32'h0000_0020, 32'hFFFF_0000, 4'hF, 3, 2, 32'h1234_5678,  1, 32'h1234_5678,  0,  7, 4);
    apb_xfer("rd_adderr", 1'b0, 32'h0001_0004, 32'h0,         4'h0, 0, 1, 32'h0,          0, 32'h0,          1,  1, 0);
    apb_xfer("rd_fast",   1'b0, 32'h0000_0024, 32'h0,         4'h0, 0, 1, 32'hA5A5_0F0F,  1, 32'hA5A5_0F0F,  0,  3, 1);
    apb_xfer("wr_nostrb", 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 4'h0, 0, 1, 32'h0,          0, 32'h0,          0,  1, 0);
    apb_xfer("wr_top",    1'b1, 32'h0000_FFFF, 32'h0000_BEEF, 4'h3, 1, 1, 32'h0,          1, 32'h0,          0,  3, 2);
    apb_xfer("wr_adderr", 1'b1, 32'h8000_0000, 32'h1111_1111, 4'hF, 0, 1, 32'h0,          0, 32'h0,          1,  1, 0);
    apb_xfer("rd_pre",    1'b0, 32'h0000_0044, 32'h0,         4'h0, 0, 1, 32'h89AB_CDEF,  1, 32'h89AB_CDEF,  0,  3, 1);

    // An rvalid with nothing outstanding must not disturb the held read data.
    stray_rv = 1;
    repeat (4) @(negedge clk);
    check("stray_rvalid_rdata", 64'(bus.apb_rdata_o), 64'h89AB_CDEF);

    // Reset while the read sits in RESP: everything clears and the late rvalid is dropped.
    begin
      req_t q;
      cfg_rdy_dly = 0;
      cfg_rv_dly  = 3;
      cfg_rdata   = 32'h55AA_55AA;
      q.addr  = 16'h0030;
      q.wdata = 32'h1111_2222;
      q.wstrb = '0;
      req_q.push_back(q);
      @(negedge clk);
      bus.apb_sel_i    = 1'b1;
      bus.apb_enable_i = 1'b0;
      bus.apb_write_i  = 1'b0;
      bus.apb_addr_i   = 32'h0000_0030;
      bus.apb_wdata_i  = 32'h1111_2222;
      bus.apb_wstrb_i  = 4'hF;
      @(negedge clk);
      bus.apb_enable_i = 1'b1;
      check("rst_req_active", 64'(bus.iob_avalid_o), 64'd1);
      @(negedge clk);
      check("rst_in_resp", 64'(bus.iob_avalid_o), 64'd0);
      rst = 1'b1;
      bus.apb_sel_i    = 1'b0;
      bus.apb_enable_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid_ready", 64'(bus.apb_ready_o), 64'd0);
      check("rst_mid_slverr", 64'(bus.apb_slverr_o), 64'd0);
      check("rst_mid_rdata", 64'(bus.apb_rdata_o), 64'd0);
      check("rst_mid_avalid", 64'(bus.iob_avalid_o), 64'd0);
      check("rst_mid_iob_addr", 64'(bus.iob_addr_o), 64'd0);
      check("rst_mid_iob_wdata", 64'(bus.iob_wdata_o), 64'd0);
      repeat (6) @(negedge clk);
      check("rst_late_rvalid_rdata", 64'(bus.apb_rdata_o), 64'd0);
      $display("xfer %-10s RD addr=0x%08h aborted by reset", "rd_reset", 32'h0000_0030);
    end

    apb_xfer("wr_postrst", 1'b1, 32'h0000_0050, 32'h0F0F_0F0F, 4'hC, 0, 1, 32'h0,       1, 32'h0,         0,  2, 1);

`ifdef APB2IOB_TIMEOUT_EN
    apb_xfer("rd_timeout", 1'b0, 32'h0000_0060, 32'h0,         4'h0, 1000, 1, 32'h0,    0, 32'h0,         1, 16, 15);
`endif

    repeat (3) @(negedge clk);
    check("resp_queue_drained", 64'(resp_q.size()), 64'd0);
    check("req_queue_drained", 64'(req_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
